// File: rtl/prbs_pkg.sv
// prbs_pkg: polynomial selection, degree/tap constants and checker states
// shared by both ends of the PRBS link.
package prbs_pkg;

    typedef enum logic [1:0] {
        MODE_PRBS7  = 2'd0,
        MODE_PRBS9  = 2'd1,
        MODE_PRBS15 = 2'd2,
        MODE_PRBS31 = 2'd3
    } prbs_mode_e;

    typedef enum logic [1:0] {
        ST_SEED,
        ST_HUNT,
        ST_LOCKED
    } chk_state_e;

    localparam int HIST_W = 31;

    localparam logic [4:0] DEG_PRBS7  = 5'd7;
    localparam logic [4:0] DEG_PRBS9  = 5'd9;
    localparam logic [4:0] DEG_PRBS15 = 5'd15;
    localparam logic [4:0] DEG_PRBS31 = 5'd31;

    localparam logic [4:0] TAPB_PRBS7  = 5'd6;
    localparam logic [4:0] TAPB_PRBS9  = 5'd5;
    localparam logic [4:0] TAPB_PRBS15 = 5'd14;
    localparam logic [4:0] TAPB_PRBS31 = 5'd28;

    // The leading tap of every supported polynomial equals its degree.
    function automatic logic [4:0] mode_degree(input prbs_mode_e m);
        return (m == MODE_PRBS7)  ? DEG_PRBS7  :
               (m == MODE_PRBS9)  ? DEG_PRBS9  :
               (m == MODE_PRBS15) ? DEG_PRBS15 : DEG_PRBS31;
    endfunction

    function automatic logic [4:0] mode_tap_b(input prbs_mode_e m);
        return (m == MODE_PRBS7)  ? TAPB_PRBS7  :
               (m == MODE_PRBS9)  ? TAPB_PRBS9  :
               (m == MODE_PRBS15) ? TAPB_PRBS15 : TAPB_PRBS31;
    endfunction

endpackage

// File: rtl/prbs_tap_sel.sv
// prbs_tap_sel: predicts the next stream bit from the received history and
// reports the degree of the selected polynomial.
module prbs_tap_sel
    import prbs_pkg::*;
(
    input  prbs_mode_e        mode,
    input  logic [HIST_W-1:0] hist,
    output logic              exp_bit,
    output logic [4:0]        degree
);

    logic [4:0] tap_b;

    always_comb begin
        degree  = mode_degree(mode);
        tap_b   = mode_tap_b(mode);
        exp_bit = hist[degree - 5'd1] ^ hist[tap_b - 5'd1];
    end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising serial PRBS checker with lock detection,
// loss-of-lock windowing and a saturating error counter.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT  = 16,
    parameter int WINDOW    = 64,
    parameter int LOSS_ERRS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic        bit_valid,
    input  logic        bit_in,
    input  logic        clr,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic        err_sat
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam int TAL_W = $clog2(LOSS_ERRS + 1);

    chk_state_e        state_q, state_d;
    prbs_mode_e        mode_q, mode_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [4:0]        seed_q, seed_d, seed_nx;
    logic [RUN_W-1:0]  run_q, run_d, run_nx;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [TAL_W-1:0]  tally_q, tally_d, tally_nx;
    logic              locked_q, locked_d;
    logic              pulse_q, pulse_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic              exp_bit, mism, cnt_err, seed_done, run_done, loss, win_end;
    logic [4:0]        degree;

    // Prediction follows the registered mode so a switch lines up with the FSM restart.
    prbs_tap_sel u_tap_sel (
        .mode    (mode_q),
        .hist    (hist_q),
        .exp_bit (exp_bit),
        .degree  (degree)
    );

    always_comb begin
        mode_d    = prbs_mode_e'(mode);
        hist_d    = bit_valid ? {hist_q[HIST_W-2:0], bit_in} : hist_q;
        mism      = bit_valid & (bit_in ^ exp_bit);
        cnt_err   = mism & (state_q == ST_LOCKED);
        seed_nx   = seed_q + 5'd1;
        run_nx    = run_q + RUN_W'(1);
        tally_nx  = tally_q + TAL_W'(mism);
        seed_done = seed_nx == degree;
        run_done  = !mism && run_nx == RUN_W'(LOCK_CNT);
        loss      = tally_nx == TAL_W'(LOSS_ERRS);
        win_end   = win_q == WIN_W'(WINDOW - 1);
        state_d   = state_q;
        seed_d    = seed_q;
        run_d     = run_q;
        win_d     = win_q;
        tally_d   = tally_q;
        if (mode_d != mode_q) begin
            state_d = ST_SEED;
            seed_d  = {4'd0, bit_valid};
            run_d   = '0;
            win_d   = '0;
            tally_d = '0;
        end else if (bit_valid) begin
            case (state_q)
                ST_SEED: begin
                    state_d = seed_done ? ST_HUNT : ST_SEED;
                    seed_d  = seed_done ? 5'd0 : seed_nx;
                    run_d   = '0;
                end
                ST_HUNT: begin
                    state_d = run_done ? ST_LOCKED : ST_HUNT;
                    run_d   = (mism || run_done) ? '0 : run_nx;
                    win_d   = '0;
                    tally_d = '0;
                end
                ST_LOCKED: begin
                    state_d = loss ? ST_SEED : ST_LOCKED;
                    seed_d  = 5'd0;
                    win_d   = (loss || win_end) ? '0 : win_q + WIN_W'(1);
                    tally_d = (loss || win_end) ? '0 : tally_nx;
                end
                default: state_d = ST_SEED;
            endcase
        end
        locked_d = state_d == ST_LOCKED;
        pulse_d  = cnt_err;
        cnt_d    = clr ? {15'd0, cnt_err} :
                   (cnt_err && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        sat_d    = (cnt_d == 16'hFFFF) | (sat_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SEED;
            mode_q   <= MODE_PRBS7;
            hist_q   <= '0;
            seed_q   <= '0;
            run_q    <= '0;
            win_q    <= '0;
            tally_q  <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            hist_q   <= hist_d;
            seed_q   <= seed_d;
            run_q    <= run_d;
            win_q    <= win_d;
            tally_q  <= tally_d;
            locked_q <= locked_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;
    assign err_sat   = sat_q;

endmodule
